// File: rtl/sram_port_adapter_pkg.sv
// Shared types and constants for the SRAM port adapter and its response queue.
package sram_port_adapter_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int unsigned MASK_MAX_W = 128;
  localparam logic [MASK_MAX_W-1:0] MASK_ALL = '1;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_resp_queue.sv
// Synchronous FIFO holding SRAM read data until the response consumer takes it.
module sram_resp_queue
  import sram_port_adapter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 3,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; count gates visibility of every entry.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sram_port_adapter.sv
// Ready/valid front end for a single-port byte-masked SRAM with 1-cycle read latency,
// with post-reset zero-fill and a credit-checked response queue.
module sram_port_adapter
  import sram_port_adapter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RESP_DEPTH = 3,
  parameter bit          INIT_EN    = 1'b1,
  localparam int unsigned MASK_W    = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned CNT_W = cnt_width(RESP_DEPTH);
  localparam state_t RESET_STATE = INIT_EN ? INIT : RUN;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] init_cnt;
  logic              inflight;
  logic              init_done_q;
  logic              fire;
  logic              pop;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  occ;
  logic              q_full;
  logic              q_empty;
  logic              unused_full;

  assign occ         = q_count + CNT_W'(inflight);
  assign unused_full = q_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RESET_STATE;
      init_cnt    <= '0;
      inflight    <= 1'b0;
      init_done_q <= !INIT_EN;
    end else begin
      state       <= state_n;
      if (state == INIT) init_cnt <= init_cnt + ADDR_W'(1);
      inflight    <= fire && !req_write;
      init_done_q <= (state_n == RUN);
    end
  end

  // Everything is gated by reset so outputs are quiet while reset is held,
  // even before the first reset edge has landed in the state register.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    fire       = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (!reset) begin
      case (state)
        INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = init_cnt;
          sram_wmask = MASK_ALL[MASK_W-1:0];
          if (init_cnt == '1) state_n = RUN;
        end
        RUN: begin
          req_ready = (occ < CNT_W'(RESP_DEPTH));
          fire      = req_valid && req_ready;
          if (fire) begin
            sram_en    = 1'b1;
            sram_wmode = req_write;
            sram_addr  = req_addr;
            sram_wmask = req_wmask;
            sram_wdata = req_wdata;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  assign resp_valid = !reset && (state == RUN) && !q_empty;
  assign pop        = resp_valid && resp_ready;
  assign init_done  = init_done_q && !reset;

  sram_resp_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (sram_rdata),
    .pop       (pop),
    .head      (resp_rdata),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_sram_port_adapter.sv
// Bench for sram_port_adapter at ADDR_W=4 with a behavioural byte-masked SRAM model.
module tb_sram_port_adapter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        init_done;
  logic [3:0]  sram_addr;
  logic        sram_en;
  logic        sram_wmode;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_port_adapter #(
    .ADDR_W     (4),
    .DATA_W     (32),
    .RESP_DEPTH (3),
    .INIT_EN    (1'b1)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    sram_rdata = $urandom;
  end

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    en_cnt = 0;
  int    overflow_cnt = 0;
  resp_t got[$];
  int    acc[$];
  logic [31:0] expq[$];
  vec_t  vecs[11];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (sram_en) en_cnt++;
    if (!reset && resp_valid && resp_ready) got.push_back('{data: resp_rdata, cyc: cyc});
    if (req_valid && req_ready && !req_write) acc.push_back(cyc);
    if (!reset && u_dut.inflight && u_dut.q_count == 3 && !(resp_valid && resp_ready))
      overflow_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_got(input string name, input int idx, input logic [31:0] exp);
    if (idx < got.size()) chk(name, got[idx].data, exp);
    else begin
      tests++;
      fails++;
      $display("FAIL %s: response %0d missing, expected 0x%0h", name, idx, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
  endtask

  task automatic send(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask);
    drive(wr, addr, wdata, wmask);
    #1;
    chk("send_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      if (!vecs[i].wr) expq.push_back(vecs[i].exp);
      #1;
      chk("vec_ready", req_ready, 1'b1);
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic check_expq(input string name);
    chk({name, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) chk_got(name, i, expq[i]);
  endtask

  initial begin
    int e0;
    int idx;
    int budget;
    int not_ready;
    int valid_seen;

    vecs[0]  = '{1'b1, 4'd3,  32'hAABBCCDD, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 4'd3,  32'h11223344, 4'h5, 32'h0};
    vecs[2]  = '{1'b0, 4'd3,  32'h0,        4'h0, 32'hAA22CC44};
    vecs[3]  = '{1'b1, 4'd9,  32'hDEADBEEF, 4'hF, 32'h0};
    vecs[4]  = '{1'b0, 4'd9,  32'h0,        4'h0, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 4'd0,  32'h01020304, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 4'd0,  32'hFFFFFFFF, 4'hA, 32'h0};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,        4'h0, 32'hFF02FF04};
    vecs[8]  = '{1'b0, 4'd7,  32'h0,        4'h0, 32'h00000000};
    vecs[9]  = '{1'b1, 4'd15, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[10] = '{1'b0, 4'd15, 32'h0,        4'h0, 32'hCAFEF00D};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
    wait_cycles(3);
    #1;
    chk("reset_outputs", {req_ready, resp_valid, init_done, sram_en, sram_wmode,
                          sram_addr, sram_wmask, sram_wdata}, 64'h0);
    tick();

    // Zero-fill: 16 writes then RUN
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init_write", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, init_done, req_ready},
          {1'b1, 1'b1, 4'(i), 4'hF, 32'h0, 1'b0, 1'b0});
      tick();
    end
    #1;
    chk("init_done_ready", {init_done, req_ready}, 2'b11);
    chk("run_idle_sram", {sram_en, sram_addr, sram_wmask, sram_wdata}, 64'h0);

    got.delete(); acc.delete();
    send(1'b0, 4'd7, 32'h0, 4'h0);
    wait_cycles(4);
    chk("init_read_count", got.size(), 1);
    chk_got("init_read_data", 0, 32'h0);
    if (got.size() > 0 && acc.size() > 0) chk("init_read_latency", got[0].cyc - acc[0], 2);

    // Byte mask, then the rest of the table
    got.delete(); expq.delete();
    e0 = en_cnt;
    apply_vecs(0, 2);
    wait_cycles(4);
    chk("bytemask_en_cycles", en_cnt - e0, 3);
    check_expq("bytemask");

    got.delete(); expq.delete();
    apply_vecs(3, 10);
    wait_cycles(4);
    check_expq("table");

    // Backpressure
    for (int a = 1; a <= 5; a++) send(1'b1, 4'(a), 32'(a * 16), 4'hF);
    got.delete();
    resp_ready = 1'b0;
    idx = 1;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'(idx), 32'h0, 4'h0);
      #1;
      if (req_ready && idx <= 5) idx++;
      tick();
    end
    chk("bp_accepts", idx - 1, 3);
    drive(1'b0, 4'(idx), 32'h0, 4'h0);
    #1;
    chk("bp_ready_low", req_ready, 1'b0);
    chk("bp_head", {resp_valid, resp_rdata}, {1'b1, 32'h10});
    resp_ready = 1'b1;
    budget = 0;
    while (idx <= 5 && budget < 20) begin
      drive(1'b0, 4'(idx), 32'h0, 4'h0);
      #1;
      if (req_ready) idx++;
      tick();
      budget++;
    end
    req_valid = 1'b0;
    chk("bp_all_accepted", idx, 6);
    wait_cycles(5);
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk_got("bp_data", i, 32'((i + 1) * 16));

    // Streaming
    for (int a = 8; a < 16; a++) send(1'b1, 4'(a), 32'h10000000 + 32'(a * 32'h111), 4'hF);
    got.delete(); acc.delete();
    not_ready = 0;
    for (int a = 8; a < 16; a++) begin
      drive(1'b0, 4'(a), 32'h0, 4'h0);
      #1;
      if (!req_ready) not_ready++;
      tick();
    end
    req_valid = 1'b0;
    wait_cycles(5);
    chk("stream_ready", not_ready, 0);
    chk("stream_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk_got("stream_data", i, 32'h10000000 + 32'((i + 8) * 32'h111));
      if (i < got.size() && acc.size() > 0) chk("stream_timing", got[i].cyc - acc[0], 2 + i);
    end

    // Reset with 2 queued and 1 in flight
    resp_ready = 1'b0;
    got.delete();
    send(1'b0, 4'd1, 32'h0, 4'h0);
    send(1'b0, 4'd2, 32'h0, 4'h0);
    send(1'b0, 4'd3, 32'h0, 4'h0);
    #1;
    chk("mid_state", {resp_valid, resp_rdata, u_dut.inflight}, {1'b1, 32'h10, 1'b1});
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {req_ready, resp_valid, init_done, sram_en, sram_wmode,
                              sram_addr, sram_wmask, sram_wdata}, 64'h0);
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("reinit_start", {sram_en, sram_wmode, sram_addr, init_done, resp_valid},
        {1'b1, 1'b1, 4'd0, 1'b0, 1'b0});
    valid_seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      #1;
      if (resp_valid) valid_seen++;
    end
    chk("reinit_done", init_done, 1'b1);
    wait_cycles(4);
    chk("no_stale_valid", valid_seen, 0);
    chk("no_stale_resp", got.size(), 0);
    send(1'b0, 4'd2, 32'h0, 4'h0);
    wait_cycles(4);
    chk("reinit_zero_count", got.size(), 1);
    chk_got("reinit_zero_data", 0, 32'h0);

    chk("no_overflow", overflow_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_port_adapter.md
Name: sram_port_adapter

Overview:
- Front-end controller for one single-port, byte-masked behavioural SRAM macro with 1-cycle registered read latency (the RW0_* port style used by the L1 data/tag arrays).
- Converts a ready/valid request stream into RW0 accesses and returns read data on a ready/valid response stream.
- Holds a credit-checked response queue, so response backpressure never drops SRAM read data.
- After reset, runs a zero-fill of the whole array, so simulation never depends on random memory init.

Parameters:
- ADDR_W, 10, SRAM word-address width (depth = 2^ADDR_W)
- DATA_W, 32, word width; must be a multiple of 8
- MASK_W, DATA_W/8, byte-lane mask width (derived, not overridable)
- RESP_DEPTH, 3, response queue entries; 3 gives full read throughput
- INIT_EN, 1, 1 = zero-fill the array after reset; 0 = go straight to RUN

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  adapter can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_wmask  in  MASK_W  byte enables (writes only)
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer accepts read data
- resp_rdata  out  DATA_W  read data, in request order
- init_done  out  1  high once zero-fill completes
- sram_addr  out  ADDR_W  to RW0_addr
- sram_en  out  1  to RW0_en
- sram_wmode  out  1  to RW0_wmode
- sram_wmask  out  MASK_W  to RW0_wmask
- sram_wdata  out  DATA_W  to RW0_wdata
- sram_rdata  in  DATA_W  from RW0_rdata; valid the cycle after a read enable

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset clears the state, init counter, queue pointers/count and inflight flag. Reset mid-operation drops in-flight reads and queued data and restarts init.
- Output values while reset is held: req_ready=0, resp_valid=0, init_done=0, sram_en=0, sram_wmode=0, sram_addr=0, sram_wmask=0, sram_wdata=0.
- FSM states: INIT and RUN. After reset: INIT if INIT_EN=1, otherwise RUN.
- INIT, per cycle:
  - drives sram_en=1, wmode=1, wmask=all-ones, wdata=0, addr=init_cnt;
  - init_cnt increments each cycle.
  - After the write to address 2^ADDR_W-1, the next state is RUN; init takes exactly 2^ADDR_W cycles.
  - In INIT: req_ready=0, resp_valid=0.
- init_done: registered; 1 in every RUN cycle, 0 in INIT.
- occ = queue count + inflight (0..RESP_DEPTH).
- req_ready = (state==RUN) && (occ < RESP_DEPTH). It does not depend on req_valid, req_write or resp_ready. Writes are also blocked at full occupancy; this is conservative and intended.
- fire = req_valid && req_ready. sram_* are combinational from the request fields when fire:
  - sram_en=fire, sram_wmode=req_write, addr/wdata/wmask passed through;
  - in RUN with no fire: sram_en=0 and the other sram outputs are 0.
- Read accepted at cycle N:
  - inflight=1 during cycle N+1;
  - sram_rdata is pushed into the queue at the end of N+1;
  - resp_valid is earliest in cycle N+2 (fixed 2-cycle minimum latency).
- Writes produce no response and commit at the accepting edge. A read accepted in the next cycle to the same address returns the new data.
- Queue:
  - FIFO; resp_rdata = head entry; pop when resp_valid && resp_ready.
  - Push and pop in the same cycle are legal, including when full.
  - Pointers wrap modulo RESP_DEPTH.
- Overflow is impossible by the credit rule; the bench asserts this. No push occurs when inflight=0.
- Back-to-back reads with resp_ready held at 1 sustain one read per cycle at RESP_DEPTH=3.

Decomposition:
- Package sram_port_adapter_pkg holds:
  - the state enum {INIT, RUN};
  - a function giving the count width as clog2(RESP_DEPTH+1);
  - the constant MASK_ALL for the all-ones mask.
- One sub-module, sram_resp_queue: a parameterised synchronous FIFO (DATA_W, RESP_DEPTH) with push/pop/count/full/empty. Its count feeds occ.

Test Plan:
- Run all scenarios at ADDR_W=4.
- Init: release reset, check 16 consecutive writes (addr 0..15, wdata 0, wmask 0xF), then init_done=1 at cycle 16. Then read addr 7 and expect resp_rdata=0x00000000 at cycle +2.
- Byte mask: write addr 3 data 0xAABBCCDD mask 0xF, then addr 3 data 0x11223344 mask 0x5, then read addr 3. Expect 0xAA22CC44; sram_en is high for exactly 3 cycles.
- Backpressure: hold resp_ready=0 and offer 5 reads (addrs 1..5, each preloaded with addr*0x10). Expect req_ready to drop after 3 accepts with no data loss. Then raise resp_ready and expect 0x10, 0x20, 0x30, followed by the remaining two in order.
- Streaming: 8 back-to-back reads with resp_ready=1. Expect req_ready to stay 1 throughout and 8 responses in consecutive cycles starting 2 cycles after the first accept.
- Write-then-read: write addr 9 = 0xDEADBEEF, read addr 9 in the next cycle. Expect 0xDEADBEEF.
- Reset mid-flight: with 2 responses queued and 1 read in flight, assert reset for 1 cycle. Expect resp_valid=0 immediately after, INIT restarting at addr 0, and no stale responses after init_done.
